// File: rtl/clave_sequencer_if.sv
// Control/status bundle between the game FSM (master) and the clave sequencer (slave).
interface clave_sequencer_if;
  logic       en;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] bars;
  logic       hit;
  logic       note;
  logic [3:0] step;
  logic [3:0] bar;
  logic       running;
  logic       done;

  modport master (
    output en, start, stop, pause, bars,
    input  hit, note, step, bar, running, done
  );

  modport slave (
    input  en, start, stop, pause, bars,
    output hit, note, step, bar, running, done
  );
endinterface

// File: rtl/clave_sequencer.sv
// Clave rhythm sequencer: divides the beat strobe into steps, walks a 16-step
// strike pattern, drives a retriggerable note gate and counts bars.
//   state | meaning
//   IDLE  | stopped, counters cleared
//   RUN   | sequencing on enabled cycles
//   HOLD  | paused, everything frozen, note level held
module clave_sequencer #(
  parameter logic [12:0] TICK_DIV = 13'd6600,
  parameter logic [15:0] PATTERN  = 16'h1449,
  parameter logic [7:0]  NOTE_LEN = 8'd200
) (
  input logic              clk,
  input logic              reset,
  clave_sequencer_if.slave sq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [12:0] tick_cnt;
  logic [12:0] tick_nxt;
  logic [3:0]  step_q;
  logic [3:0]  step_nxt;
  logic [3:0]  step_inc;
  logic [3:0]  bar_q;
  logic [3:0]  bar_nxt;
  logic [3:0]  bars_lat;
  logic [3:0]  bars_lat_nxt;
  logic [7:0]  note_cnt;
  logic [7:0]  note_cnt_nxt;
  logic        hit_q;
  logic        hit_nxt;
  logic        note_q;
  logic        done_q;
  logic        done_nxt;
  logic        running_q;

  logic active;
  logic advance;
  logic step_end;
  logic bar_end;
  logic last_bar;
  logic finish;

  // A sequence position moves only when active, enabled and not held by pause,
  // so leaving HOLD on an enabled cycle already counts that cycle.
  assign active   = (state == RUN) || (state == HOLD);
  assign advance  = active && sq.en && !sq.pause;
  assign step_end = (tick_cnt == (TICK_DIV - 13'd1));
  assign step_inc = step_q + 4'd1;
  assign bar_end  = step_end && (step_q == 4'd15);
  assign last_bar = (bars_lat != 4'd0) && ((bar_q + 4'd1) == bars_lat);
  assign finish   = advance && bar_end && last_bar;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (sq.stop) begin
      state_nxt = IDLE;
    end else if (sq.start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (sq.pause)  state_nxt = HOLD;
          else if (finish) state_nxt = IDLE;
        end
        HOLD: begin
          if (!sq.pause) state_nxt = finish ? IDLE : RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    tick_nxt     = tick_cnt;
    step_nxt     = step_q;
    bar_nxt      = bar_q;
    bars_lat_nxt = bars_lat;
    note_cnt_nxt = note_cnt;
    hit_nxt      = 1'b0;
    done_nxt     = 1'b0;

    if (advance && (note_cnt != 8'd0)) begin
      note_cnt_nxt = note_cnt - 8'd1;
    end

    if (sq.stop) begin
      tick_nxt     = '0;
      step_nxt     = '0;
      bar_nxt      = '0;
      note_cnt_nxt = '0;
    end else if (sq.start) begin
      bars_lat_nxt = sq.bars;
      tick_nxt     = '0;
      step_nxt     = '0;
      bar_nxt      = '0;
      hit_nxt      = PATTERN[0];
    end else if (advance) begin
      if (!step_end) begin
        tick_nxt = tick_cnt + 13'd1;
      end else if (bar_end && last_bar) begin
        // Final bar complete: no strike on the wrap, gate cut immediately.
        tick_nxt     = '0;
        step_nxt     = '0;
        bar_nxt      = '0;
        note_cnt_nxt = '0;
        done_nxt     = 1'b1;
      end else begin
        tick_nxt = '0;
        step_nxt = step_inc;
        hit_nxt  = PATTERN[step_inc];
        if (bar_end) bar_nxt = bar_q + 4'd1;
      end
    end

    // A strike reloads the gate, overriding the decrement on the same cycle.
    if (hit_nxt) begin
      note_cnt_nxt = NOTE_LEN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      step_q    <= '0;
      bar_q     <= '0;
      bars_lat  <= '0;
      note_cnt  <= '0;
      hit_q     <= 1'b0;
      note_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tick_cnt  <= tick_nxt;
      step_q    <= step_nxt;
      bar_q     <= bar_nxt;
      bars_lat  <= bars_lat_nxt;
      note_cnt  <= note_cnt_nxt;
      hit_q     <= hit_nxt;
      note_q    <= (note_cnt_nxt != 8'd0);
      done_q    <= done_nxt;
      running_q <= (state_nxt != IDLE);
    end
  end

  assign sq.hit     = hit_q;
  assign sq.note    = note_q;
  assign sq.step    = step_q;
  assign sq.bar     = bar_q;
  assign sq.running = running_q;
  assign sq.done    = done_q;

endmodule

// File: tb/tb_clave_sequencer.sv
// Bench for clave_sequencer: two parameterisations driven in lockstep and checked
// every cycle against a position-based model, plus table vectors and directed sequences.
module tb_clave_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, start, stop, pause;
  logic [3:0] bars;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clave_sequencer_if ifa ();
  clave_sequencer_if ifb ();

  assign ifa.en = en;  assign ifa.start = start;  assign ifa.stop = stop;
  assign ifa.pause = pause;  assign ifa.bars = bars;
  assign ifb.en = en;  assign ifb.start = start;  assign ifb.stop = stop;
  assign ifb.pause = pause;  assign ifb.bars = bars;

  clave_sequencer #(.TICK_DIV(13'd4), .PATTERN(16'h1449), .NOTE_LEN(8'd200)) dut_a (
    .clk(clk), .reset(reset), .sq(ifa.slave)
  );
  clave_sequencer #(.TICK_DIV(13'd2), .PATTERN(16'h1449), .NOTE_LEN(8'd3)) dut_b (
    .clk(clk), .reset(reset), .sq(ifb.slave)
  );

  // Model tracks the number of advancing cycles since start ("pos"); everything
  // else is plain arithmetic on it.
  typedef struct {
    int          td;
    int          nl;
    logic [15:0] pat;
    int          mode;     // 0 idle, 1 run, 2 hold
    int          pos;
    int          lat;
    int          hit_pos;
    bit          has_hit;
    bit          hit;
    bit          done;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t minit(int td, int nl, logic [15:0] pat);
    mdl_t m;
    m.td = td; m.nl = nl; m.pat = pat;
    m.mode = 0; m.pos = 0; m.lat = 0; m.hit_pos = 0;
    m.has_hit = 0; m.hit = 0; m.done = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit rst, bit e, bit st, bit sp, bit pz, logic [3:0] b);
    m.hit = 0;
    m.done = 0;
    if (rst) begin
      m.mode = 0; m.pos = 0; m.lat = 0; m.has_hit = 0;
    end else if (sp) begin
      m.mode = 0; m.pos = 0; m.has_hit = 0;
    end else if (st) begin
      m.mode = 1; m.lat = int'(b); m.pos = 0;
      m.hit = m.pat[0];
      if (m.hit) begin m.hit_pos = 0; m.has_hit = 1; end
    end else if (m.mode != 0 && pz) begin
      m.mode = 2;
    end else if (m.mode != 0) begin
      m.mode = 1;
      if (e) begin
        m.pos++;
        if (m.lat != 0 && m.pos == m.lat * 16 * m.td) begin
          m.mode = 0; m.pos = 0; m.has_hit = 0; m.done = 1;
        end else if (m.pos % m.td == 0) begin
          m.hit = m.pat[(m.pos / m.td) % 16];
          if (m.hit) begin m.hit_pos = m.pos; m.has_hit = 1; end
        end
      end
    end
    return m;
  endfunction

  // {hit, note, step, bar, running, done}
  function automatic logic [11:0] mexp(mdl_t m);
    logic [3:0] s  = 4'((m.pos / m.td) % 16);
    logic [3:0] br = 4'((m.pos / (16 * m.td)) % 16);
    logic       nt = m.has_hit && ((m.pos - m.hit_pos) < m.nl);
    return {m.hit, nt, s, br, (m.mode != 0), m.done};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ma = mstep(ma, reset, en, start, stop, pause, bars);
    mb = mstep(mb, reset, en, start, stop, pause, bars);
    chk("model_a", {ifa.hit, ifa.note, ifa.step, ifa.bar, ifa.running, ifa.done}, mexp(ma));
    chk("model_b", {ifb.hit, ifb.note, ifb.step, ifb.bar, ifb.running, ifb.done}, mexp(mb));
  endtask

  task automatic go_idle();
    start = 0; pause = 0; stop = 1; tick(); stop = 0;
  endtask

  typedef struct {
    bit st, sp, pz, e;
    logic [3:0] b;
    bit x_hit;
    logic [3:0] x_step;
    bit x_run;
    bit x_done;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int s_at, last_chg, prev_step;
    bit note_at, bad, bad2, saw_wrap;
    logic [3:0] prev_bar;

    tbl[0]  = '{1, 0, 0, 1, 4'd2, 1, 4'd0, 1, 0};
    tbl[1]  = '{0, 0, 0, 1, 4'd0, 0, 4'd0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 4'd0, 0, 4'd0, 1, 0};
    tbl[3]  = '{0, 0, 0, 1, 4'd0, 0, 4'd0, 1, 0};
    tbl[4]  = '{0, 0, 0, 1, 4'd0, 0, 4'd0, 1, 0};
    tbl[5]  = '{0, 0, 0, 1, 4'd0, 0, 4'd1, 1, 0};
    tbl[6]  = '{0, 0, 1, 1, 4'd0, 0, 4'd1, 1, 0};
    tbl[7]  = '{1, 0, 1, 1, 4'd0, 1, 4'd0, 1, 0};
    tbl[8]  = '{0, 0, 0, 1, 4'd0, 0, 4'd0, 1, 0};
    tbl[9]  = '{1, 1, 0, 1, 4'd0, 0, 4'd0, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 4'd0, 1, 4'd0, 1, 0};
    tbl[12] = '{0, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0};

    ma = minit(4, 200, 16'h1449);
    mb = minit(2, 3, 16'h1449);
    en = 0; start = 0; stop = 0; pause = 0; bars = 0; reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    chk("reset_outputs_a", {ifa.hit, ifa.note, ifa.step, ifa.bar, ifa.running, ifa.done}, 12'h0);

    // Table vectors on the TICK_DIV=4 instance
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; pause = tbl[i].pz; en = tbl[i].e; bars = tbl[i].b;
      tick();
      chk($sformatf("tbl%0d", i), {ifa.hit, ifa.step, ifa.running, ifa.done},
          {tbl[i].x_hit, tbl[i].x_step, tbl[i].x_run, tbl[i].x_done});
    end
    start = 0; stop = 0; pause = 0; bars = 0;

    // One bar, default pattern
    en = 1; bars = 1; start = 1; tick(); start = 0;
    for (int c = 1; c <= 70; c++) begin
      chk($sformatf("onebar_hit_c%0d", c), ifa.hit,
          (c == 1 || c == 13 || c == 25 || c == 41 || c == 49));
      chk($sformatf("onebar_done_c%0d", c), ifa.done, (c == 65));
      if (c == 65) chk("onebar_running_at_done", ifa.running, 0);
      tick();
    end

    // Reset mid-run
    go_idle();
    bars = 0; start = 1; tick(); start = 0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1; tick(); reset = 0;
    chk("rst_midrun_a", {ifa.hit, ifa.note, ifa.step, ifa.bar, ifa.running, ifa.done}, 12'h0);
    chk("rst_midrun_b", {ifb.hit, ifb.note, ifb.step, ifb.bar, ifb.running, ifb.done}, 12'h0);

    // Gated timebase on the TICK_DIV=2 instance
    en = 0; start = 1; tick(); start = 0;
    last_chg = -1; prev_step = 0; bad = 0;
    for (int c = 1; c <= 48; c++) begin
      en = c[0];
      tick();
      if (int'(ifb.step) != prev_step) begin
        if (last_chg >= 0 && (c - last_chg) != 4) bad = 1;
        last_chg = c;
        prev_step = int'(ifb.step);
      end
    end
    chk("gated_step_len4", bad, 0);
    chk("gated_steps_seen", (prev_step >= 10), 1);

    // Pause at step 5
    go_idle();
    en = 1; bars = 0; start = 1; tick(); start = 0;
    for (int c = 0; c < 100 && ifa.step != 4'd5; c++) tick();
    chk("pause_reach_step5", ifa.step, 5);
    note_at = ifa.note;
    pause = 1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ifa.step != 4'd5 || ifa.hit || ifa.note != note_at || !ifa.running) bad = 1;
    end
    chk("pause_frozen", bad, 0);
    pause = 0;
    bad = 0;
    for (int c = 0; c < 3; c++) begin tick(); if (ifa.hit) bad = 1; end
    chk("pause_no_early_hit", bad, 0);
    tick();
    chk("pause_delayed_hit", {ifa.hit, ifa.step}, {1'b1, 4'd6});

    // Stop and start together at step 7, then a clean restart
    for (int c = 0; c < 100 && ifa.step != 4'd7; c++) tick();
    chk("stopstart_reach_step7", ifa.step, 7);
    stop = 1; start = 1; tick(); stop = 0; start = 0;
    chk("stopstart_idle", {ifa.running, ifa.done, ifa.hit, ifa.step, ifa.note}, 8'h0);
    tick(); tick();
    chk("stopstart_stays_idle", {ifa.running, ifa.done}, 2'b00);
    start = 1; tick(); start = 0;
    chk("restart_step0_hit", {ifa.hit, ifa.step, ifa.running}, {1'b1, 4'd0, 1'b1});

    // Retrigger keeps the long gate continuously high
    bad = 0;
    for (int c = 0; c < 200; c++) begin tick(); if (!ifa.note) bad = 1; end
    chk("retrigger_note_high", bad, 0);

    // Loop mode on the TICK_DIV=2 instance: 17+ bars
    go_idle();
    bars = 0; start = 1; tick(); start = 0;
    bad = 0; bad2 = 0; saw_wrap = 0; prev_bar = 0;
    for (int c = 0; c < 17 * 32 + 8; c++) begin
      tick();
      if (ifb.done) bad = 1;
      if (!ifb.running) bad2 = 1;
      if (prev_bar == 4'd15 && ifb.bar == 4'd0) saw_wrap = 1;
      prev_bar = ifb.bar;
    end
    chk("loop_no_done", bad, 0);
    chk("loop_running", bad2, 0);
    chk("loop_bar_wrap", saw_wrap, 1);

    // Random control traffic against the model
    go_idle();
    for (int c = 0; c < 4000; c++) begin
      en    = ($urandom_range(3) != 0);
      start = ($urandom_range(90) == 0);
      stop  = ($urandom_range(250) == 0);
      if ($urandom_range(40) == 0) pause = ~pause;
      bars  = 4'($urandom_range(3));
      reset = ($urandom_range(1500) == 0);
      tick();
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clave_sequencer.md
# clave_sequencer

Rhythm sequencer that schedules clave strikes on the shared beat timebase. It divides an upstream enable strobe into steps. It walks a 16-step strike pattern, pulses `hit` on active steps and produces a retriggerable note gate. It runs start/stop/pause control and an optional bar count, and sits between the game/control FSM and the sound/display datapath.

## Interface
- `TICK_DIV`, 13'd6600: enabled cycles per step; legal range 1..8191.
- `PATTERN`, 16'h1449: strike pattern; bit n = step n, bit 0 first. Default is 3-2 son clave, steps 0,3,6,10,12.
- `NOTE_LEN`, 8'd200: enabled cycles the note gate stays high after a hit; 0 disables the gate.

- `clk` in 1: single clock, all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: timebase strobe; counters advance only on cycles with `en`=1.
- `start` in 1: begin or restart the sequence from step 0.
- `stop` in 1: abort to idle.
- `pause` in 1: level; freezes the sequence while high.
- `bars` in 4: bars to play, sampled at start; 0 = loop forever.
- `hit` out 1: one-cycle strike pulse.
- `note` out 1: note gate.
- `step` out 4: current step 0..15.
- `bar` out 4: bars completed in the current run, wraps mod 16.
- `running` out 1: high in RUN or HOLD.
- `done` out 1: one-cycle pulse when the bar count completes.

## Operation
- States:
  - IDLE: stopped, counters cleared.
  - RUN: sequencing.
  - HOLD: paused, everything frozen.
- Command priority: `reset` > `stop` > `start` > `pause`.
- Reset: state IDLE. Step counter, `step`, `bar`, note counter and latched bars all 0. Outputs `hit`, `note`, `step`, `bar`, `running`, `done` all 0.
- IDLE + `start`: go to RUN. Latch `bars`. Clear step counter, `step` and `bar`. `hit` = PATTERN[0]; a hit loads the note counter.
- RUN/HOLD + `start`: same restart as from IDLE, including the hit on step 0.
- RUN/HOLD + `stop`: go to IDLE. Clear counters and the note gate. No `done`.
- RUN + `pause`: go to HOLD. In HOLD:
  - step counter, note counter, `step` and `bar` are frozen;
  - `hit`=0;
  - `note` holds its value.
- HOLD + !`pause`: go back to RUN and resume from the frozen count. No extra hit.
- Step counter in RUN with `en`=1:
  - below TICK_DIV-1: increments;
  - at TICK_DIV-1: clears to 0 and `step` advances, raising `hit` = PATTERN[new step].
- `en`=0 in RUN: no counter changes.
- Bar wrap (step 15 → 0 while advancing):
  - If latched bars ≠ 0 and `bar`+1 == latched bars: go to IDLE, pulse `done`, clear counters and the note gate, no hit.
  - Otherwise: `bar` increments mod 16, step becomes 0, `hit` = PATTERN[0].
- Note counter:
  - A hit loads NOTE_LEN, including a retrigger while the gate is still high.
  - Otherwise it decrements on RUN cycles with `en`=1 until it reaches 0.
  - `note` = (note counter ≠ 0), registered.
- `running` = state is RUN or HOLD.

## Timing
- Every output is registered; each response appears the cycle after the input or event that causes it.
- `start` sampled on cycle t: `running`=1, `step`=0 and `hit`=PATTERN[0] all on t+1.
- With `en` tied high:
  - each step lasts exactly TICK_DIV cycles;
  - a bar lasts 16·TICK_DIV cycles;
  - the step k hit occurs at t+1+k·TICK_DIV.
- `hit` and `done` are single-cycle pulses and are never high in the same cycle.
- `note` rises in the same cycle as `hit` and stays high for NOTE_LEN enabled RUN cycles, excluding HOLD cycles.
- Hit and decrement on the same cycle: the load wins.
- `start` and `pause` on the same cycle: the restart takes effect and the block enters RUN, not HOLD.
- Changes to `bars` while running are ignored.

## Test plan
- Reset mid-run:
  - Stimulus: TICK_DIV=4, `en`=1, start, then `reset` on cycle 10.
  - Required: cycle 11 shows every output 0 and state IDLE.
- One bar with default PATTERN:
  - Stimulus: TICK_DIV=4, `bars`=1, `start` on cycle 0.
  - Required: `hit` on cycles 1, 13, 25, 41, 49. `done` on cycle 65 with `running`=0. No hit on cycle 65.
- Gated timebase and note gate:
  - Stimulus: `en` high every other cycle, TICK_DIV=2, NOTE_LEN=3.
  - Required: steps last 4 cycles. `note` high for exactly 3 enabled cycles after each hit.
- Pause:
  - Stimulus: pause for 20 cycles at step 5.
  - Required: `step` stays 5, `hit`=0 and `note` frozen during the pause. The next hit is delayed by exactly 20 cycles.
- Loop mode:
  - Stimulus: `bars`=0, 17 bars.
  - Required: `bar` wraps 15 → 0, `done` never asserts, `running` stays 1.
- Stop vs restart:
  - Stimulus: `stop` and `start` asserted together at step 7.
  - Required: IDLE, `running`=0, no done. A later `start` alone restarts at step 0 with a hit.
- Retrigger:
  - Stimulus: NOTE_LEN=200, TICK_DIV=4.
  - Required: `note` stays high continuously, reloaded at each hit.
